// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and single-port memory signals seen by mem_port_arbiter.
// slave is the arbiter's view; master is the view of the pipeline plus memory around it.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall_out;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, d_rdata, d_valid, stall_out, bus_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, stall_out, bus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store stage.
// Data port wins arbitration, a starvation guard forces fetch progress, a watchdog aborts hangs.
module mem_port_arbiter #(
  parameter int unsigned StarveMax = 4,
  parameter int unsigned Timeout   = 255
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_port_arbiter_if.slave io_bus
);

  localparam logic [7:0] StarveLim = 8'(StarveMax);
  localparam logic [7:0] WdLast    = 8'(Timeout - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_owner;  // 0: fetch, 1: data
  logic [7:0]  r_starve_cnt;
  logic [7:0]  r_wd_cnt;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_bus_err;

  logic w_arb;
  logic w_if_cand;
  logic w_d_cand;
  logic w_grant_d;
  logic w_grant_f;
  logic w_grant;
  logic w_wd_expire;
  logic w_if_valid;
  logic w_d_valid;

  // In DONE the finishing owner still holds its req for one more cycle, so it is masked out.
  assign w_arb       = (r_state == StIdle) || (r_state == StDone);
  assign w_if_cand   = w_arb && io_bus.if_req && !((r_state == StDone) && !r_owner);
  assign w_d_cand    = w_arb && io_bus.d_req && !((r_state == StDone) && r_owner);
  assign w_grant_d   = w_d_cand && !(w_if_cand && (r_starve_cnt == StarveLim));
  assign w_grant_f   = w_if_cand && !w_grant_d;
  assign w_grant     = w_grant_d || w_grant_f;
  assign w_wd_expire = (r_wd_cnt == WdLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_grant) w_state_d = StBusy;
      StBusy:  if (io_bus.mem_ready || w_wd_expire) w_state_d = StDone;
      StDone:  w_state_d = w_grant ? StBusy : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner      <= 1'b0;
      r_starve_cnt <= 8'd0;
      r_wd_cnt     <= 8'd0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_if_rdata   <= 32'd0;
      r_d_rdata    <= 32'd0;
      r_bus_err    <= 1'b0;
    end else if (w_grant) begin
      r_owner     <= w_grant_d;
      r_mem_we    <= w_grant_d && io_bus.d_we;
      r_mem_addr  <= w_grant_d ? io_bus.d_addr : io_bus.if_addr;
      r_mem_wdata <= w_grant_d ? io_bus.d_wdata : 32'd0;
      r_wd_cnt    <= 8'd0;
      if (w_grant_f) begin
        r_starve_cnt <= 8'd0;
      end else if (w_if_cand) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end else if (r_state == StBusy) begin
      if (io_bus.mem_ready) begin
        if (!r_owner) begin
          r_if_rdata <= io_bus.mem_rdata;
        end else if (!r_mem_we) begin
          r_d_rdata <= io_bus.mem_rdata;
        end
      end else if (w_wd_expire) begin
        // Aborted access still completes, with zero data and a sticky error.
        r_bus_err <= 1'b1;
        if (r_owner) begin
          r_d_rdata <= 32'd0;
        end else begin
          r_if_rdata <= 32'd0;
        end
      end else begin
        r_wd_cnt <= r_wd_cnt + 8'd1;
      end
    end
  end

  assign w_if_valid = (r_state == StDone) && !r_owner;
  assign w_d_valid  = (r_state == StDone) && r_owner;

  assign io_bus.if_valid  = w_if_valid;
  assign io_bus.d_valid   = w_d_valid;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.d_rdata   = r_d_rdata;
  assign io_bus.bus_err   = r_bus_err;
  assign io_bus.mem_req   = (r_state == StBusy);
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.stall_out = (io_bus.if_req && !w_if_valid) || (io_bus.d_req && !w_d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model of which port the memory serves and what each access returns.
module tb_mem_port_arbiter;
  localparam int StarveMax = 4;
  localparam int Timeout   = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .StarveMax(StarveMax),
    .Timeout  (Timeout)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: which port the memory is serving (-1 none), which port completes this cycle.
  int          serving   = -1;
  int          finishing = -1;
  int          busy_n    = 0;
  int          starve    = 0;
  logic        m_bus_err = 1'b0;
  logic [31:0] m_if_rdata = 32'd0;
  logic [31:0] m_d_rdata  = 32'd0;
  logic [31:0] refmem [logic [31:0]];

  // Requester state
  logic        f_pend = 1'b0;
  logic [31:0] f_addr = 32'd0;
  logic        d_pend = 1'b0;
  logic        d_we   = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;

  int ready_mode = 1;  // 0 random, 1 fixed latency, 2 never
  int ready_lat  = 3;
  bit noise      = 1'b0;
  bit rnd_req    = 1'b0;

  int          done_f = -1;
  int          done_d = -1;
  logic [31:0] obs_if = 32'd0;
  logic [31:0] obs_d  = 32'd0;
  int          f_valid_cnt = 0;
  int          d_valid_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (refmem.exists(a)) return refmem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic drive_reqs();
    bus.if_req  = f_pend;
    bus.if_addr = f_addr;
    bus.d_req   = d_pend;
    bus.d_we    = d_we;
    bus.d_addr  = d_addr;
    bus.d_wdata = d_wdata;
  endtask

  // One clock: drive memory response, compare DUT to model, advance the model.
  task automatic cycle();
    int          n_serving;
    int          n_finishing;
    int          n_busy;
    int          n_starve;
    logic        n_err;
    logic [31:0] n_ifr;
    logic [31:0] n_dr;
    logic        rdy;
    logic [31:0] rdata;
    logic        f_ok;
    logic        d_ok;
    logic        exp_stall;
    drive_reqs();
    @(negedge clk);
    rdy = 1'b0;
    if (serving >= 0) begin
      case (ready_mode)
        0:       rdy = ($urandom_range(0, 2) == 0);
        1:       rdy = (busy_n == ready_lat);
        default: rdy = 1'b0;
      endcase
    end else begin
      rdy = noise && ($urandom_range(0, 3) == 0);
    end
    rdata = $urandom;
    if (serving == 0) rdata = mem_read(f_addr);
    else if (serving == 1 && !d_we) rdata = mem_read(d_addr);
    bus.mem_ready = rdy;
    bus.mem_rdata = rdata;

    exp_stall = (f_pend && finishing != 0) || (d_pend && finishing != 1);
    check("mem_req", 32'(bus.mem_req), 32'(serving >= 0));
    check("if_valid", 32'(bus.if_valid), 32'(finishing == 0));
    check("d_valid", 32'(bus.d_valid), 32'(finishing == 1));
    check("stall_out", 32'(bus.stall_out), 32'(exp_stall));
    check("bus_err", 32'(bus.bus_err), 32'(m_bus_err));
    if (serving >= 0) begin
      check("mem_addr", bus.mem_addr, (serving == 1) ? d_addr : f_addr);
      check("mem_we", 32'(bus.mem_we), 32'(serving == 1 && d_we));
      if (serving == 1 && d_we) check("mem_wdata", bus.mem_wdata, d_wdata);
    end
    if (bus.if_valid) f_valid_cnt++;
    if (bus.d_valid) d_valid_cnt++;
    if (finishing == 0) begin
      check("if_rdata", bus.if_rdata, m_if_rdata);
      done_f = cyc;
      obs_if = bus.if_rdata;
    end
    if (finishing == 1) begin
      check("d_rdata", bus.d_rdata, m_d_rdata);
      done_d = cyc;
      obs_d  = bus.d_rdata;
    end

    n_serving = serving; n_finishing = -1; n_busy = busy_n; n_starve = starve;
    n_err = m_bus_err; n_ifr = m_if_rdata; n_dr = m_d_rdata;
    if (serving >= 0) begin
      if (rdy) begin
        n_finishing = serving;
        n_serving   = -1;
        if (serving == 0) n_ifr = rdata;
        else if (!d_we) n_dr = rdata;
        else refmem[d_addr] = d_wdata;
      end else if (busy_n == Timeout) begin
        n_finishing = serving;
        n_serving   = -1;
        n_err       = 1'b1;
        if (serving == 0) n_ifr = 32'd0;
        else n_dr = 32'd0;
      end else begin
        n_busy = busy_n + 1;
      end
    end else begin
      // The port completing this cycle is not re-served from the same request.
      f_ok = f_pend && finishing != 0;
      d_ok = d_pend && finishing != 1;
      if (d_ok && !(f_ok && starve == StarveMax)) begin
        n_serving = 1; n_busy = 1;
        if (f_ok) n_starve = starve + 1;
      end else if (f_ok) begin
        n_serving = 0; n_busy = 1; n_starve = 0;
      end
    end
    if (rst) begin
      n_serving = -1; n_finishing = -1; n_starve = 0; n_busy = 0;
      n_err = 1'b0; n_ifr = 32'd0; n_dr = 32'd0;
    end

    @(posedge clk);
    cyc++;
    #1;
    if (finishing == 0 || rst) f_pend = 1'b0;
    if (finishing == 1 || rst) d_pend = 1'b0;
    if (rnd_req) begin
      if (!f_pend && finishing != 0 && $urandom_range(0, 2) == 0) begin
        f_pend = 1'b1;
        f_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!d_pend && finishing != 1 && $urandom_range(0, 2) == 0) begin
        d_pend  = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'h100 + (32'($urandom_range(0, 15)) << 2);
        d_wdata = $urandom;
      end
    end
    serving = n_serving; finishing = n_finishing; busy_n = n_busy; starve = n_starve;
    m_bus_err = n_err; m_if_rdata = n_ifr; m_d_rdata = n_dr;
    drive_reqs();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((f_pend || d_pend || serving >= 0 || finishing >= 0) && n < limit) begin
      cycle();
      n++;
    end
    check("drain_idle", 32'(f_pend || d_pend || serving >= 0), 32'd0);
  endtask

  initial begin
    int k;
    int f_base;
    int d_base;
    int stores_left;
    bit keep_fetch;

    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 32'd0; bus.d_wdata = 32'd0; bus.mem_rdata = 32'd0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_valids", 32'({bus.if_valid, bus.d_valid}), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Lone fetch, memory answers on the third BUSY cycle.
    refmem[32'h40] = 32'h8C01_0004;
    ready_mode = 1; ready_lat = 3;
    f_pend = 1'b1; f_addr = 32'h40; done_f = -1; k = cyc;
    for (int i = 0; i < 20 && done_f < 0; i++) cycle();
    check("fetch_seen", 32'(done_f >= 0), 32'd1);
    check("fetch_latency", 32'(done_f - k), 32'd4);
    check("fetch_rdata", obs_if, 32'h8C01_0004);
    drain(10);

    // Simultaneous requests: load first, fetch straight from DONE.
    refmem[32'h100] = 32'h1122_3344;
    f_pend = 1'b1; f_addr = 32'h44;
    d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    done_f = -1; done_d = -1; k = cyc;
    for (int i = 0; i < 30 && done_f < 0; i++) cycle();
    check("both_d_latency", 32'(done_d - k), 32'd4);
    check("both_f_latency", 32'(done_f - k), 32'd8);
    check("both_d_rdata", obs_d, 32'h1122_3344);
    drain(10);

    // Store leaves d_rdata alone; a following load sees the stored word.
    d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; done_d = -1;
    for (int i = 0; i < 20 && done_d < 0; i++) cycle();
    check("sw_d_rdata_kept", obs_d, 32'h1122_3344);
    drain(10);
    d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h200; done_d = -1;
    for (int i = 0; i < 20 && done_d < 0; i++) cycle();
    check("lw_after_sw", obs_d, 32'hDEAD_BEEF);
    drain(10);

    // Five back-to-back stores with fetch continuously requesting.
    ready_lat = 2; stores_left = 5; keep_fetch = 1'b1;
    f_base = f_valid_cnt; d_base = d_valid_cnt;
    for (int i = 0; i < 100 && (d_valid_cnt - d_base) < 5; i++) begin
      if (!d_pend && stores_left > 0) begin
        d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h300 + 32'(4 * (5 - stores_left));
        d_wdata = $urandom; stores_left--;
      end
      if (!f_pend && keep_fetch) begin
        f_pend = 1'b1; f_addr = f_addr + 32'd4;
      end
      cycle();
    end
    check("starve_stores_done", 32'(d_valid_cnt - d_base), 32'd5);
    check("starve_fetch_progress", 32'((f_valid_cnt - f_base) >= 1), 32'd1);
    drain(20);

    // Hung load: watchdog aborts after 255 BUSY cycles.
    ready_mode = 2;
    d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h104; done_d = -1; k = cyc;
    for (int i = 0; i < 300 && done_d < 0; i++) cycle();
    check("wd_seen", 32'(done_d >= 0), 32'd1);
    check("wd_latency", 32'(done_d - k), 32'd256);
    check("wd_d_rdata", obs_d, 32'd0);
    cycle();
    check("wd_bus_err_sticky", 32'(bus.bus_err), 32'd1);
    drain(10);

    // Reset in the middle of a fetch.
    f_pend = 1'b1; f_addr = 32'h48;
    repeat (3) cycle();
    check("pre_rst_busy", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_bus_err", 32'(bus.bus_err), 32'd0);
    f_base = f_valid_cnt;
    repeat (4) cycle();
    check("rst_mid_no_valid", 32'(f_valid_cnt - f_base), 32'd0);

    // Random traffic with stray mem_ready pulses outside BUSY.
    ready_mode = 0; noise = 1'b1; rnd_req = 1'b1;
    repeat (3000) cycle();
    rnd_req = 1'b0;
    drain(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
